// File: rtl/fir_multimode.sv
// fir_multimode: time-multiplexed FIR filter, one MAC per clock.
// Modes: 0 = low-pass (coefficients as stored), 1 = high-pass (spectral
// inversion), 2/3 = bypass with the same latency as the filter paths.
// Optional build macro FIR_SAT_EN: saturate the result to the DW range;
// without it the result wraps (low DW bits kept).
//
// state | meaning
// IDLE  | waiting for a sample strobe edge; coefficient writes accepted
// MAC   | TAPS cycles, one product accumulated per cycle (newest sample first)
// OUT   | one cycle; dout/dout_valid load on the edge that ends it
module fir_multimode #(
  parameter int DW   = 12,
  parameter int CW   = 16,
  parameter int TAPS = 32,
  parameter int CF   = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      f_s,
  input  logic signed [DW-1:0]      din,
  input  logic [1:0]                mode,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [CW-1:0]      coef_wdata,
  output logic signed [DW-1:0]      dout,
  output logic                      dout_valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int AW   = $clog2(TAPS);
  localparam int PW   = DW + CW;
  localparam int ACCW = DW + CW + AW;

  localparam logic signed [ACCW-1:0] RND  = {{(ACCW-CF){1'b0}}, 1'b1, {(CF-1){1'b0}}};
  localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                 state, state_nxt;
  logic                   start;
  logic                   fs_sync1, fs_sync2, fs_prev, fs_edge;
  logic signed [DW-1:0]   dline [TAPS];
  logic signed [CW-1:0]   coef  [TAPS];
  logic [AW-1:0]          wr_ptr, newest, cnt, k, rd_idx;
  logic signed [DW-1:0]   din_q;
  logic [1:0]             mode_q;
  logic signed [ACCW-1:0] acc;
  logic signed [DW-1:0]   x_cur;
  logic signed [CW-1:0]   h_cur;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] prod_ext, term, rnd_sum, shifted;
  logic signed [DW-1:0]   result;
  logic                   coef_wr_ok;

  assign fs_edge    = fs_sync2 & ~fs_prev;
  assign busy       = (state != IDLE) | dout_valid;
  assign coef_wr_ok = coef_we & ~busy;

  // Strobe synchroniser plus previous-value flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      fs_sync1 <= 1'b0;
      fs_sync2 <= 1'b0;
      fs_prev  <= 1'b0;
    end else begin
      fs_sync1 <= f_s;
      fs_sync2 <= fs_sync1;
      fs_prev  <= fs_sync2;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; start marks the capture cycle.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: if (fs_edge) begin
        state_nxt = MAC;
        start     = 1'b1;
      end
      MAC:  if (cnt == '0) state_nxt = OUT;
      OUT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Current product: k counts up as cnt counts down; odd taps negated in HPF.
  always_comb begin
    k        = ~cnt;
    rd_idx   = newest - k;
    x_cur    = dline[rd_idx];
    h_cur    = coef[k];
    prod     = x_cur * h_cur;
    prod_ext = {{AW{prod[PW-1]}}, prod};
    term     = (mode_q == 2'd1 && k[0]) ? -prod_ext : prod_ext;
  end

  // Round half up, scale by CF, then reduce to DW bits.
  always_comb begin
    rnd_sum = acc + RND;
    shifted = rnd_sum >>> CF;
`ifdef FIR_SAT_EN
    if (shifted > MAXV)      result = MAXV[DW-1:0];
    else if (shifted < MINV) result = MINV[DW-1:0];
    else                     result = DW'(shifted);
`else
    result = DW'(shifted);
`endif
    if (mode_q[1]) result = din_q;
  end

  // Datapath: coefficient file, delay line, accumulator, outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        dline[i] <= '0;
        coef[i]  <= '0;
      end
      wr_ptr     <= '0;
      newest     <= '0;
      cnt        <= '0;
      din_q      <= '0;
      mode_q     <= '0;
      acc        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (coef_wr_ok) coef[coef_addr] <= coef_wdata;
      if (fs_edge && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (start) begin
          din_q          <= din;
          mode_q         <= mode;
          dline[wr_ptr]  <= din;
          newest         <= wr_ptr;
          wr_ptr         <= wr_ptr + 1'b1;
          acc            <= '0;
          cnt            <= AW'(TAPS - 1);
        end
        MAC: begin
          acc <= acc + term;
          cnt <= cnt - 1'b1;
        end
        OUT: begin
          dout       <= result;
          dout_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_multimode.sv
// tb_fir_multimode: randomized and directed checks of fir_multimode against
// an arithmetic reference model (sample history + coefficient array).
module tb_fir_multimode;

  localparam int DW   = 12;
  localparam int CW   = 16;
  localparam int TAPS = 32;
  localparam int CF   = 15;
  localparam int AW   = $clog2(TAPS);
  localparam int LAT  = TAPS + 4;  // strobe rise to dout_valid, in clk edges

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 f_s = 1'b0;
  logic signed [DW-1:0] din = '0;
  logic [1:0]           mode = '0;
  logic                 coef_we = 1'b0;
  logic [AW-1:0]        coef_addr = '0;
  logic signed [CW-1:0] coef_wdata = '0;
  logic signed [DW-1:0] dout;
  logic                 dout_valid, busy, overrun;

  int checks = 0;
  int errors = 0;
  int hist [TAPS];
  int hm   [TAPS];

  fir_multimode #(.DW(DW), .CW(CW), .TAPS(TAPS), .CF(CF)) dut (
    .clk(clk), .rst(rst), .f_s(f_s), .din(din), .mode(mode),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .dout(dout), .dout_valid(dout_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < TAPS; i++) begin
      hist[i] = 0;
      hm[i]   = 0;
    end
  endfunction

  // Push a sample, return the expected output for it.
  function automatic int model_step(int x, logic [1:0] m);
    longint acc, r;
    for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
    if (m[1]) return x;
    acc = 0;
    for (int i = 0; i < TAPS; i++) begin
      if (m == 2'd1 && (i % 2) == 1) acc -= longint'(hist[i]) * longint'(hm[i]);
      else                           acc += longint'(hist[i]) * longint'(hm[i]);
    end
    r = (acc + (longint'(1) <<< (CF - 1))) >>> CF;
`ifdef FIR_SAT_EN
    if (r > (longint'(1) <<< (DW - 1)) - 1) r = (longint'(1) <<< (DW - 1)) - 1;
    if (r < -(longint'(1) <<< (DW - 1)))    r = -(longint'(1) <<< (DW - 1));
`else
    r = r & ((longint'(1) <<< DW) - 1);
    if (r >= (longint'(1) <<< (DW - 1))) r -= (longint'(1) <<< DW);
`endif
    return int'(r);
  endfunction

  task automatic write_coef(input int a, input int v);
    @(posedge clk); #1;
    coef_we = 1'b1; coef_addr = AW'(a); coef_wdata = CW'(v);
    @(posedge clk); #1;
    coef_we = 1'b0;
    hm[a] = v;
  endtask

  // One full sample. Optional coefficient write in the edge cycle (ew) and
  // one during MAC (bw, must be discarded).
  task automatic run_sample(input int x, input logic [1:0] m,
                            input bit ew, input int ea, input int ev,
                            input bit bw, input int ba, input int bv,
                            input string tag, output int got);
    int lat, busy_at, expv;
    bit busy_at_valid;
    lat = -1; busy_at = -1; got = 0; busy_at_valid = 1'b0;
    if (ew) hm[ea] = ev;
    expv = model_step(x, m);
    @(posedge clk); #1;
    din = DW'(x); mode = m; f_s = 1'b1;
    for (int c = 1; c <= LAT + 8; c++) begin
      @(posedge clk); #1;
      if (c == 2 && ew) begin coef_we = 1'b1; coef_addr = AW'(ea); coef_wdata = CW'(ev); end
      if (c == 3) coef_we = 1'b0;
      if (c == 10 && bw) begin coef_we = 1'b1; coef_addr = AW'(ba); coef_wdata = CW'(bv); end
      if (c == 11) coef_we = 1'b0;
      if (c == 4) f_s = 1'b0;
      if (busy && busy_at < 0) busy_at = c;
      if (dout_valid) begin lat = c; got = dout; busy_at_valid = busy; break; end
    end
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL %s latency got %0d want %0d", tag, lat, LAT); end
    checks++;
    if (busy_at !== 3) begin errors++; $display("FAIL %s busy_start got %0d want 3", tag, busy_at); end
    checks++;
    if (got !== expv) begin errors++; $display("FAIL %s dout got %0d want %0d", tag, got, expv); end
    checks++;
    if (busy_at_valid !== 1'b1) begin errors++; $display("FAIL %s busy_in_valid got %0b want 1", tag, busy_at_valid); end
    @(posedge clk); #1;
    checks++;
    if (dout_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s after_valid valid=%0b busy=%0b want 0 0", tag, dout_valid, busy);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    checks++;
    if ({dout, dout_valid, busy, overrun} !== '0) begin
      errors++; $display("FAIL reset outputs dout=%0d valid=%0b busy=%0b ovr=%0b want 0", dout, dout_valid, busy, overrun);
    end
  endtask

  task automatic test_impulse();
    int got;
    write_coef(0, 16384);
    run_sample(1000, 2'd0, 0, 0, 0, 0, 0, 0, "impulse", got);
    checks++;
    if (got !== 500) begin errors++; $display("FAIL impulse_value got %0d want 500", got); end
  endtask

  task automatic test_dc();
    int got;
    for (int i = 0; i < TAPS; i++) write_coef(i, 1024);
    for (int i = 0; i < TAPS; i++) run_sample(2047, 2'd0, 0, 0, 0, 0, 0, 0, "dc_lpf", got);
    checks++;
    if (got !== 2047) begin errors++; $display("FAIL dc_lpf_settle got %0d want 2047", got); end
    for (int i = 0; i < 2; i++) run_sample(2047, 2'd1, 0, 0, 0, 0, 0, 0, "dc_hpf", got);
    checks++;
    if (got !== 0) begin errors++; $display("FAIL dc_hpf_settle got %0d want 0", got); end
  endtask

  task automatic test_saturation();
    int got, want;
`ifdef FIR_SAT_EN
    want = 2047;
`else
    want = -34;
`endif
    for (int i = 0; i < TAPS; i++) write_coef(i, 32767);
    for (int i = 0; i < TAPS; i++) run_sample(2047, 2'd0, 0, 0, 0, 0, 0, 0, "sat", got);
    checks++;
    if (got !== want) begin errors++; $display("FAIL sat_value got %0d want %0d", got, want); end
  endtask

  task automatic test_bypass();
    int got;
    run_sample(-1234, 2'd2, 0, 0, 0, 0, 0, 0, "bypass", got);
    checks++;
    if (got !== -1234) begin errors++; $display("FAIL bypass_value got %0d want -1234", got); end
  endtask

  task automatic test_random();
    int got;
    for (int i = 0; i < TAPS; i++)
      write_coef(i, int'($urandom_range(0, 65535)) - 32768);
    for (int n = 0; n < 24; n++) begin
      int x, ea, ev, ba, bv;
      logic [1:0] m;
      bit ew, bw;
      x  = int'($urandom_range(0, 4095)) - 2048;
      m  = 2'($urandom_range(0, 3));
      ew = 1'($urandom_range(0, 1));
      bw = 1'($urandom_range(0, 1));
      ea = int'($urandom_range(0, TAPS - 1));
      ba = int'($urandom_range(0, TAPS - 1));
      ev = int'($urandom_range(0, 65535)) - 32768;
      bv = int'($urandom_range(0, 65535)) - 32768;
      run_sample(x, m, ew, ea, ev, bw, ba, bv, "random", got);
    end
  endtask

  task automatic test_overrun();
    int n_valid, got, expv;
    n_valid = 0; got = 0;
    expv = model_step(300, 2'd0);
    @(posedge clk); #1;
    din = 12'sd300; mode = 2'd0; f_s = 1'b1;
    for (int c = 1; c <= LAT + 30; c++) begin
      @(posedge clk); #1;
      if (c == 4)  f_s = 1'b0;
      if (c == 10) f_s = 1'b1;
      if (c == 14) f_s = 1'b0;
      if (dout_valid) begin n_valid++; got = dout; end
    end
    checks++;
    if (n_valid !== 1) begin errors++; $display("FAIL overrun_pulses got %0d want 1", n_valid); end
    checks++;
    if (got !== expv) begin errors++; $display("FAIL overrun_dout got %0d want %0d", got, expv); end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got %0b want 1", overrun); end
    run_sample(-77, 2'd0, 0, 0, 0, 0, 0, 0, "after_overrun", got);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %0b want 1", overrun); end
  endtask

  task automatic test_rst_mid();
    int n_valid, got;
    n_valid = 0;
    @(posedge clk); #1;
    din = -12'sd500; mode = 2'd0; f_s = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 4) f_s = 1'b0;
      if (dout_valid) n_valid++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    checks++;
    if ({dout, dout_valid, busy, overrun} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs dout=%0d valid=%0b busy=%0b ovr=%0b want 0", dout, dout_valid, busy, overrun);
    end
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (dout_valid) n_valid++;
    end
    checks++;
    if (n_valid !== 0) begin errors++; $display("FAIL rst_mid_pulses got %0d want 0", n_valid); end
    run_sample(1000, 2'd0, 0, 0, 0, 0, 0, 0, "post_rst_impulse", got);
    checks++;
    if (got !== 0) begin errors++; $display("FAIL post_rst_coef_zero got %0d want 0", got); end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_dc();
    test_bypass();
    test_random();
    test_saturation();
    test_overrun();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_multimode.md
FIR_MULTIMODE -- requirements
Module: fir_multimode

Interface
- REQ-001: Parameter DW, 12, signed sample width of din/dout, SHALL be respected.
- REQ-002: Parameter CW, 16, signed coefficient width, SHALL be respected.
- REQ-003: Parameter TAPS, 32, tap count (power of two, 4..256), SHALL be respected.
- REQ-004: Parameter CF, 15, coefficient fraction bits, SHALL be respected.
- REQ-005: One clock; reset is synchronous and active-high: clk in 1 system clock; rst in 1 synchronous active-high reset.
- REQ-006: f_s in 1 sample strobe, asynchronous level; each rising edge requests one output sample.
- REQ-007: din in DW signed input sample.
- REQ-008: mode in 2 selects filtering: 0 = LPF (coefficients as stored), 1 = HPF (spectral inversion), 2/3 = bypass.
- REQ-009: coef_we in 1 coefficient write enable.
- REQ-010: coef_addr in log2(TAPS) coefficient index.
- REQ-011: coef_wdata in CW signed coefficient value.
- REQ-012: dout out DW signed filtered sample, registered.
- REQ-013: dout_valid out 1 one-cycle pulse when dout updates.
- REQ-014: busy out 1 high while a sample is being computed.
- REQ-015: overrun out 1 sticky flag: an f_s edge was dropped.

Function
- REQ-016: f_s SHALL pass a 2-flop synchroniser and a rising-edge detector in the clk domain; f_s high and low phases are each at least 3 clk cycles.
- REQ-017: FSM states SHALL be IDLE, MAC, OUT; IDLE->MAC on a detected edge, MAC->OUT after exactly TAPS cycles, OUT->IDLE after one cycle.
- REQ-018: On edge detection in IDLE (cycle E), din and mode SHALL be captured, din written into a TAPS-deep circular delay line, and the accumulator cleared.
- REQ-019: In MAC, one product per cycle SHALL be accumulated: acc += x[k]*h[k]*s[k], where k=0 is the newest sample, s[k]=+1 in LPF, s[k]=(-1)^k in HPF.
- REQ-020: Accumulator width SHALL be DW+CW+log2(TAPS) bits; no internal overflow.
- REQ-021: Output SHALL be (acc + 2^(CF-1)) arithmetically shifted right by CF, then reduced to DW bits per REQ-030/031.
- REQ-022: In bypass, dout SHALL equal the captured din with identical latency and dout_valid timing.
- REQ-023: dout and dout_valid SHALL update on the clock edge ending OUT, giving dout_valid high in cycle E+TAPS+2, for exactly one cycle.
- REQ-024: busy SHALL be high from cycle E+1 through the cycle dout_valid is high.
- REQ-025: An edge detected while not IDLE SHALL be dropped and set overrun; the sample in progress completes unaffected.
- REQ-026: Coefficient writes SHALL take effect only in IDLE; writes while busy are discarded.
- REQ-027: An edge and coef_we in the same IDLE cycle: write is performed and the sample uses the new coefficient.
- REQ-028: Delay-line pointer SHALL wrap modulo TAPS.

Reset
- REQ-029: On rst high at a clk edge: FSM to IDLE, delay line, coefficients, pointer, accumulator, synchroniser flops, dout, dout_valid, busy, overrun all zero; rst mid-MAC aborts the sample with no dout_valid.

Configuration
- REQ-030: With macro FIR_SAT_EN defined, the result SHALL saturate to [-2^(DW-1), 2^(DW-1)-1].
- REQ-031: Without FIR_SAT_EN, the result SHALL wrap (low DW bits kept).

Verification
- REQ-032: Impulse: h[0]=16384, others 0, mode 0, din=1000 -> dout=500, dout_valid at E+34 (TAPS=32).
- REQ-033: DC: all h=1024, din=2047 held 32 samples -> mode 0 settles at dout=2047; mode 1 settles at dout=0.
- REQ-034: Saturation: all h=32767, din=2047, 32 samples, mode 0 -> FIR_SAT_EN: dout=2047; without: dout=-34.
- REQ-035: Bypass: mode=2, din=-1234 -> dout=-1234 at E+34, same pulse width.
- REQ-036: Overrun: second f_s edge 10 cycles after first -> one dout_valid only, overrun=1 until rst.
- REQ-037: rst asserted at E+10 -> no dout_valid, all outputs 0, coefficients read back as zero in subsequent impulse test.
